// File: rtl/countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_ctrl
// Description : Command-driven minutes:seconds countdown sequencer. It clamps
//               the preset, divides the system clock into a 1 s tick and
//               walks the min/sec counters down to 00:00.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] min_in,
    input  logic [5:0] sec_in,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    output logic [5:0] cur_min,
    output logic [5:0] cur_sec,
    output logic [2:0] state,
    output logic       busy,
    output logic       tick,
    output logic       done,
    output logic       expired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOADED = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_PRESC_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [5:0]       c_MAX_VAL    = 6'd59;

    state_t           r_state_q, w_state_d;
    logic [5:0]       r_min_q, w_min_d;
    logic [5:0]       r_sec_q, w_sec_d;
    logic [CNT_W-1:0] r_presc_q, w_presc_d;
    logic             r_tick_q, w_tick_d;
    logic             r_done_q, w_done_d;
    logic             r_busy_q, r_expired_q;

    logic [5:0]       w_min_clamp, w_sec_clamp;
    logic             w_cmd_load, w_cmd_pause, w_cmd_start;
    logic             w_wrap;

    // Preset clamping and one-hot command decode in abort > load > pause > start order
    always_comb begin
        w_min_clamp = (min_in > c_MAX_VAL) ? c_MAX_VAL : min_in;
        w_sec_clamp = (sec_in > c_MAX_VAL) ? c_MAX_VAL : sec_in;
        w_cmd_load  = !abort && load;
        w_cmd_pause = !abort && !load && pause;
        w_cmd_start = !abort && !load && !pause && start;
        w_wrap      = (r_presc_q == c_PRESC_LAST);
    end

    // Next-state, counter and prescaler logic for the sequencer
    always_comb begin
        w_state_d = r_state_q;
        w_min_d   = r_min_q;
        w_sec_d   = r_sec_q;
        w_presc_d = r_presc_q;
        w_tick_d  = 1'b0;
        w_done_d  = 1'b0;

        if (abort) begin
            // Cancel from any state without reporting completion
            w_state_d = S_IDLE;
            w_min_d   = 6'd0;
            w_sec_d   = 6'd0;
            w_presc_d = '0;
        end else begin
            case (r_state_q)
                S_IDLE, S_LOADED, S_DONE, S_PAUSE: begin
                    if (w_cmd_load) begin
                        w_state_d = S_LOADED;
                        w_min_d   = w_min_clamp;
                        w_sec_d   = w_sec_clamp;
                        w_presc_d = '0;
                    end else if (w_cmd_start && r_state_q == S_LOADED) begin
                        // A zero preset completes immediately without a tick
                        if (r_min_q == 6'd0 && r_sec_q == 6'd0) begin
                            w_state_d = S_DONE;
                            w_done_d  = 1'b1;
                        end else begin
                            w_state_d = S_RUN;
                            w_presc_d = '0;
                        end
                    end else if (w_cmd_start && r_state_q == S_PAUSE) begin
                        // Resume with the held prescaler so no cycles are lost
                        w_state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_cmd_pause) begin
                        // Pause beats a coincident wrap: prescaler simply holds
                        w_state_d = S_PAUSE;
                    end else if (w_wrap) begin
                        w_presc_d = '0;
                        w_tick_d  = 1'b1;
                        if (r_sec_q != 6'd0) begin
                            w_sec_d = r_sec_q - 6'd1;
                        end else begin
                            w_sec_d = c_MAX_VAL;
                            w_min_d = r_min_q - 6'd1;
                        end
                        // RUN never holds 00:00, so 00:01 is the last step
                        if (r_min_q == 6'd0 && r_sec_q == 6'd1) begin
                            w_state_d = S_DONE;
                            w_done_d  = 1'b1;
                        end
                    end else begin
                        w_presc_d = r_presc_q + 1'b1;
                    end
                end
                default: begin
                    w_state_d = S_IDLE;
                    w_min_d   = 6'd0;
                    w_sec_d   = 6'd0;
                    w_presc_d = '0;
                end
            endcase
        end
    end

    // State and output registers; status flags decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_min_q     <= 6'd0;
            r_sec_q     <= 6'd0;
            r_presc_q   <= '0;
            r_tick_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_busy_q    <= 1'b0;
            r_expired_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_min_q     <= w_min_d;
            r_sec_q     <= w_sec_d;
            r_presc_q   <= w_presc_d;
            r_tick_q    <= w_tick_d;
            r_done_q    <= w_done_d;
            r_busy_q    <= (w_state_d == S_RUN) || (w_state_d == S_PAUSE);
            r_expired_q <= (w_state_d == S_DONE);
        end
    end

    assign cur_min = r_min_q;
    assign cur_sec = r_sec_q;
    assign state   = r_state_q;
    assign busy    = r_busy_q;
    assign tick    = r_tick_q;
    assign done    = r_done_q;
    assign expired = r_expired_q;

endmodule
`default_nettype wire

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
- Command-driven sequencer for the minutes:seconds countdown datapath.
- Accepts load, start, pause and abort commands.
- Validates and clamps the preset time, then generates the 1 Hz tick from the system clock via a prescaler.
- Drives the min/sec down-counters and reports completion; sits between the front-panel/host command logic and the display/alarm logic.

Parameters:
- TICK_DIV, 50000000, clock cycles per 1-second tick (50 MHz clock); benches use a small value, e.g. 4.
- CNT_W, 26, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- load  input  1  one-cycle command: capture min_in/sec_in.
- min_in  input  6  preset minutes, valid when load=1.
- sec_in  input  6  preset seconds, valid when load=1.
- start  input  1  one-cycle command: begin or resume countdown.
- pause  input  1  one-cycle command: freeze countdown.
- abort  input  1  one-cycle command: cancel and return to IDLE.
- cur_min  output  6  current minutes remaining.
- cur_sec  output  6  current seconds remaining.
- state  output  3  IDLE=0, LOADED=1, RUN=2, PAUSE=3, DONE=4.
- busy  output  1  high in RUN or PAUSE.
- tick  output  1  one-cycle pulse on each applied 1 s decrement.
- done  output  1  one-cycle pulse on entry to DONE.
- expired  output  1  level, high while in DONE.

Behaviour:
- All state updates on rising edge of clk. rst=1 forces state=IDLE, cur_min=0, cur_sec=0, prescaler=0, busy=0, tick=0, done=0, expired=0; it overrides any command in the same cycle.
- Command priority in a single cycle: abort > load > pause > start. Lower-priority commands in the same cycle are ignored. Commands illegal in the current state are ignored with no side effect.
- Clamping: min_in>59 captured as 59; sec_in>59 captured as 59.
- IDLE:
  - load -> LOADED, capture clamped values, prescaler=0.
  - start -> ignored.
- LOADED:
  - load -> re-capture, stay LOADED.
  - start with captured 00:00 -> DONE next edge (done pulses, no tick).
  - start otherwise -> RUN, prescaler=0.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 each cycle and wraps to 0 at TICK_DIV-1.
  - On the wrap cycle apply a decrement and pulse tick in the same edge. Decrement: sec>0 -> sec-1; sec=0 -> sec=59, min-1.
  - If the decrement yields 00:00 -> DONE on the same edge, and done pulses with the final tick.
  - pause -> PAUSE; prescaler holds its value. If pause coincides with the wrap cycle, pause wins and no decrement occurs.
  - load -> ignored.
- PAUSE:
  - start -> RUN, resuming from the held prescaler value (no lost or extra cycles).
  - load -> LOADED with new values, prescaler=0.
- DONE:
  - expired=1, cur_min=cur_sec=0.
  - load -> LOADED.
  - start -> ignored.
- abort in any state -> IDLE, counters and prescaler cleared, no done pulse.
- First-tick latency: from the start edge, first tick occurs exactly TICK_DIV cycles later. Total RUN duration for preset M:S = (60*M+S)*TICK_DIV cycles, excluding pauses.
- done and tick are registered outputs, high for exactly one cycle. busy, expired and state are registered.
- Counters never underflow; 00:00 is reachable only via DONE, LOADED or IDLE.

Test Plan (TICK_DIV=4):
- Reset then load 01:30, start -> ticks every 4 cycles; after 4 ticks cur=01:26; 01:00 -> 00:59 on the wrap; done pulses once at cycle 360 after start; state=4, expired=1.
- Load min_in=63, sec_in=60 -> cur=59:59, state=LOADED; reload 00:00 then start -> DONE on the next edge, done=1 for one cycle, tick never asserted.
- Load 00:05, start, pause at 2 cycles after start, hold 10 cycles, start -> first tick lands 2 cycles after resume; total run cycles (pause excluded) = 20.
- In RUN, assert pause exactly on the prescaler wrap cycle -> no tick, cur unchanged, state=PAUSE.
- Same-cycle abort+load in RUN -> IDLE, cur=00:00; same-cycle load+start in LOADED -> stays LOADED with the new value.
- Assert rst mid-RUN at 00:03 -> next edge all outputs zero, state=IDLE; a subsequent start is ignored.
